// File: rtl/trng_pkg.sv
// Shared constants and FSM state encoding for the TRNG-to-UART byte scheduler.
package trng_pkg;

  localparam logic [7:0] SYNC_BYTE         = 8'hA5;
  localparam int         HANDSHAKE_TIMEOUT = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_WAIT_HI = 2'd2,
    ST_WAIT_LO = 2'd3
  } sched_state_t;

endpackage

// File: rtl/trng_byte_fifo.sv
// Synchronous byte FIFO with occupancy count; a push while full is taken only
// when a pop frees a slot in the same cycle.
module trng_byte_fifo
  import trng_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [7:0]             i_data,
  output logic [7:0]             o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_level == (AW+1)'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_head    = r_mem[r_rd_ptr];
  assign o_level   = r_level;

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/trng_uart_scheduler.sv
// Packs sampled TRNG bits into bytes, buffers them and feeds a UART one byte at a time.
// Define TRNG_SYNC_HDR_EN to prefix every FRAME_LEN data bytes with a sync header.
module trng_uart_scheduler
  import trng_pkg::*;
#(
  parameter int BIT_DIV    = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int FRAME_LEN  = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        rnd_bit,
  output logic                        tx_send,
  output logic [7:0]                  tx_data,
  input  logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow
);

  localparam logic [7:0] DIV_LAST = 8'(BIT_DIV - 1);
  localparam logic [2:0] TO_LAST  = 3'(HANDSHAKE_TIMEOUT - 1);

  sched_state_t r_state;
  sched_state_t w_next;
  logic [7:0]   r_div;
  logic [7:0]   r_shift;
  logic [2:0]   r_bit_cnt;
  logic [2:0]   r_to_cnt;
  logic         r_push_pend;
  logic         w_sample;
  logic         w_pop;
  logic         w_full;
  logic         w_empty;
  logic         w_need_hdr;
  logic         w_is_hdr;
  logic [7:0]   w_head;

  assign w_sample = en & (r_div == DIV_LAST);

  // Bit sampler and MSB-first packer; en low throws away any partial byte
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div       <= 8'd0;
      r_shift     <= 8'd0;
      r_bit_cnt   <= 3'd0;
      r_push_pend <= 1'b0;
    end else begin
      r_push_pend <= 1'b0;
      if (!en) begin
        r_div     <= 8'd0;
        r_shift   <= 8'd0;
        r_bit_cnt <= 3'd0;
      end else if (w_sample) begin
        r_div       <= 8'd0;
        r_shift     <= {r_shift[6:0], rnd_bit};
        r_bit_cnt   <= r_bit_cnt + 3'd1;
        r_push_pend <= (r_bit_cnt == 3'd7);
      end else begin
        r_div <= r_div + 8'd1;
      end
    end
  end

  trng_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_push_pend),
    .i_pop   (w_pop),
    .i_data  (r_shift),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  // Sticky drop flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) overflow <= 1'b0;
    else if (r_push_pend && w_full && !w_pop) overflow <= 1'b1;
  end

`ifdef TRNG_SYNC_HDR_EN
  logic [15:0] r_frame_left;
  logic        r_is_hdr;

  assign w_need_hdr = (r_frame_left == 16'd0);
  assign w_is_hdr   = r_is_hdr;

  // Data bytes still owed in the current frame; zero means a header goes next
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_left <= 16'd0;
      r_is_hdr     <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && w_next == ST_SEND) r_is_hdr <= w_need_hdr;
      if (r_state == ST_SEND) r_frame_left <= r_is_hdr ? 16'(FRAME_LEN) : r_frame_left - 16'd1;
    end
  end
`else
  assign w_need_hdr = 1'b0;
  assign w_is_hdr   = 1'b0;
  if (FRAME_LEN < 1) begin : g_frame_len_unused
  end
`endif

  // State register; strobe and byte are loaded as SEND is entered
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_to_cnt <= 3'd0;
      tx_send  <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      r_state  <= w_next;
      tx_send  <= (w_next == ST_SEND);
      r_to_cnt <= (r_state == ST_WAIT_HI) ? r_to_cnt + 3'd1 : 3'd0;
      if (r_state == ST_IDLE && w_next == ST_SEND) tx_data <= w_need_hdr ? SYNC_BYTE : w_head;
    end
  end

  // Next-state logic for the one-byte-in-flight handshake
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (!w_empty && !tx_busy) w_next = ST_SEND; else w_next = ST_IDLE;
      ST_SEND:    w_next = ST_WAIT_HI;
      ST_WAIT_HI: if (tx_busy) w_next = ST_WAIT_LO;
                  else if (r_to_cnt == TO_LAST) w_next = ST_IDLE;
                  else w_next = ST_WAIT_HI;
      ST_WAIT_LO: if (!tx_busy) w_next = ST_IDLE; else w_next = ST_WAIT_LO;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Headers are generated here, so only data sends consume a FIFO entry
  always_comb begin
    w_pop = 1'b0;
    if (r_state == ST_SEND && !w_is_hdr) w_pop = 1'b1;
    else w_pop = 1'b0;
  end

endmodule
